imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory that the fetch stage reads. It receives a byte stream over a

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the fetch path.
package imem_loader_pkg;

   localparam int unsigned IMEM_ADDR_W = 8;
   localparam int unsigned STATE_W     = 3;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned WORD_W      = 32;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input and imem write port of the boot loader.
interface imem_loader_if
   import imem_loader_pkg::*;
   #(parameter int unsigned ADDR_W = IMEM_ADDR_W)
   ();

   logic [BYTE_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte shift register; full flags the push that completes a word.
module byte_packer
   import imem_loader_pkg::*;
   (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              push,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic              full
   );

   logic [WORD_W-1:0] sr_q;
   logic [1:0]        cnt_q;

   // Shift each accepted byte in from the low end; the first byte ends up in [31:24].
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (push) begin
         sr_q  <= {sr_q[WORD_W-BYTE_W-1:0], byte_in};
         cnt_q <= cnt_q + 2'd1;
      end
   end

   assign word = sr_q;
   assign full = push && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: packs a byte stream into 32-bit words, writes them from
// word 0 upward and holds the CPU in reset until the image is loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing 32-bit checksum word).
module imem_loader
   import imem_loader_pkg::*;
   #(parameter int unsigned ADDR_W = IMEM_ADDR_W)
   (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   imem_loader_if.slave      bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
   );

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  word_cnt_q;
   logic              byte_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              cpu_hold_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q, err_nxt;
   logic              start_ok;
   logic              accept;
   logic [WORD_W-1:0] pk_word;
   logic              pk_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q;
`endif

   assign accept = bus.byte_valid && byte_ready_q;

   // One packer serves both the data words and the trailing checksum word.
   byte_packer u_packer (
      .clock   (clock),
      .reset   (reset),
      .clr     (start_ok),
      .push    (accept),
      .byte_in (bus.byte_in),
      .word    (pk_word),
      .full    (pk_full)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // Next-state and next-error decode.
   always_comb begin
      state_nxt = state_q;
      err_nxt   = err_q;
      start_ok  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               start_ok  = 1'b1;
               err_nxt   = 1'b0;
               state_nxt = (load_len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (pk_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (word_cnt_q + LEN_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = ST_CHECK;
`else
               state_nxt = ST_DONE;
`endif
            end else begin
               state_nxt = ST_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            // The completing byte is not in the packer yet, so splice it in here.
            if (pk_full) begin
               state_nxt = ST_DONE;
               err_nxt   = ({pk_word[WORD_W-BYTE_W-1:0], bus.byte_in} != sum_q);
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs, length/word counters and running checksum.
   always_ff @(posedge clock) begin
      if (reset) begin
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         cpu_hold_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         len_q        <= '0;
         word_cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         byte_ready_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
         mem_we_q     <= (state_nxt == ST_WRITE);
         busy_q       <= (state_nxt == ST_LOAD) || (state_nxt == ST_WRITE) ||
                         (state_nxt == ST_CHECK);
         done_q       <= (state_nxt == ST_DONE);
         err_q        <= err_nxt;
         cpu_hold_q   <= (state_nxt == ST_DONE) ? err_nxt : 1'b1;
         if (state_nxt == ST_WRITE) mem_addr_q <= word_cnt_q[ADDR_W-1:0];
         if (start_ok) begin
            len_q      <= (load_len > MAX_LEN) ? MAX_LEN : load_len;
            word_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
         end else if (state_q == ST_WRITE) begin
            word_cnt_q <= word_cnt_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + pk_word;
`endif
         end
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = pk_word;
   assign cpu_hold       = cpu_hold_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomised bench for imem_loader with a word-level reference model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned AW  = IMEM_ADDR_W;
   localparam int unsigned LW  = AW + 1;
   localparam int          CAP = 1 << AW;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   load_len;
   logic          cpu_hold, busy, done, error;

   imem_loader_if #(.ADDR_W(AW)) bus ();

   imem_loader #(.ADDR_W(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .load_len (load_len),
      .bus      (bus.slave),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0]   img[$];
   logic [7:0]    stream[$];

   // Observation log, owned by the monitor; cleared on reset or an accepted start.
   int            cyc = 0;
   int            acc_n;
   int            acc4_cyc[$];
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            wr_cyc[$];
   int            ready_we;
   int            done_rise;
   logic          done_d = 1'b0;

   always @(negedge clock) begin
      cyc++;
      if (reset || (start && !busy)) begin
         acc_n = 0;
         acc4_cyc.delete();
         wr_addr.delete();
         wr_data.delete();
         wr_cyc.delete();
         ready_we  = 0;
         done_rise = -1;
      end else begin
         if (bus.byte_valid && bus.byte_ready) begin
            acc_n++;
            if (acc_n % 4 == 0) acc4_cyc.push_back(cyc);
         end
         if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cyc);
            if (bus.byte_ready) ready_we++;
         end
         if (done && !done_d && done_rise < 0) done_rise = cyc;
      end
      done_d = done;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle1();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endtask

   task automatic fill_random(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
   endtask

   // Byte image for nw words, plus the trailing checksum word when that feature is built.
   task automatic build_stream(input int nw, input bit bad_cs, output bit exp_err);
      logic [31:0] sum;
      sum = '0;
      exp_err = 1'b0;
      stream.delete();
      for (int i = 0; i < nw; i++) begin
         push_word(img[i]);
         sum += img[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (nw > 0) begin
         push_word(sum + 32'(bad_cs));
         exp_err = bad_cs;
      end
`else
      if (bad_cs) exp_err = 1'b0;
`endif
   endtask

   task automatic pulse_start(input int len);
      cycle1();
      start    = 1'b1;
      load_len = LW'(len);
      cycle1();
      start    = 1'b0;
   endtask

   // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
   task automatic send_stream(input int lo, input int hi, input int mode);
      int idx, guard;
      bit acc, v;
      idx = lo;
      guard = 0;
      while (idx < hi && guard < 4000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         bus.byte_valid = v;
         bus.byte_in    = stream[idx];
         @(negedge clock);
         acc = bus.byte_valid && bus.byte_ready;
         cycle1();
         if (acc) idx++;
         guard++;
      end
      bus.byte_valid = 1'b0;
      chk("stream_sent", 64'(idx), 64'(hi));
   endtask

   task automatic wait_done(input int bound);
      int g;
      g = 0;
      while (!done && g < bound) begin
         cycle1();
         g++;
      end
      chk("done_timeout", 64'(done), 64'(1));
      repeat (2) cycle1();
   endtask

   // Compare the logged writes against the model: word i of img at address i,
   // one cycle after its 4th byte.
   task automatic check_writes(input int nw);
      int bad;
      bad = 0;
      chk("wr_count", 64'(wr_addr.size()), 64'(nw));
      for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
         if (i < 2) begin
            chk("wr_addr", 64'(wr_addr[i]), 64'(i));
            chk("wr_data", 64'(wr_data[i]), 64'(img[i]));
         end else if (wr_addr[i] != AW'(i) || wr_data[i] != img[i]) begin
            bad++;
         end
         if (acc4_cyc.size() <= i || wr_cyc[i] != acc4_cyc[i] + 1) bad++;
      end
      chk("wr_content_timing", 64'(bad), 64'(0));
      chk("ready_in_write", 64'(ready_we), 64'(0));
   endtask

   task automatic run_load(input int len_req, input int mode, input bit bad_cs);
      int nw;
      bit exp_err;
      nw = (len_req > CAP) ? CAP : len_req;
      build_stream(nw, bad_cs, exp_err);
      pulse_start(len_req);
      send_stream(0, stream.size(), mode);
      wait_done(64);
      check_writes(nw);
      chk("busy_end", 64'(busy), 64'(0));
      chk("error_end", 64'(error), 64'(exp_err));
      chk("hold_end", 64'(cpu_hold), 64'(exp_err));
      if (nw > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (acc4_cyc.size() > 0) chk("done_lat", 64'(done_rise), 64'(acc4_cyc[$] + 1));
`else
         if (wr_cyc.size() > 0) chk("done_lat", 64'(done_rise), 64'(wr_cyc[$] + 1));
`endif
      end
   endtask

   initial begin
      bit dummy_err;
      int rdy;
      reset          = 1'b1;
      start          = 1'b0;
      load_len       = '0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;

      // Reset state.
      repeat (2) cycle1();
      chk("rst_hold", 64'(cpu_hold), 64'(1));
      chk("rst_ready", 64'(bus.byte_ready), 64'(0));
      chk("rst_we", 64'(bus.mem_we), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_error", 64'(error), 64'(0));
      chk("rst_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst_wdata", 64'(bus.mem_wdata), 64'(0));
      reset = 1'b0;
      cycle1();

      // Fixed two-word image, back-to-back then with valid toggling.
      img.delete();
      img.push_back(32'h2008_0005);
      img.push_back(32'h3C01_0010);
      run_load(2, 0, 1'b0);
      chk("done_b2b", 64'(done), 64'(1));
      run_load(2, 1, 1'b0);

      // Zero-length load completes on the next cycle without writing.
      pulse_start(0);
      chk("len0_done", 64'(done), 64'(1));
      chk("len0_busy", 64'(busy), 64'(0));
      repeat (3) cycle1();
      chk("len0_writes", 64'(wr_addr.size()), 64'(0));

      // Start while busy is ignored.
      fill_random(2);
      build_stream(2, 1'b0, dummy_err);
      pulse_start(2);
      send_stream(0, 2, 0);
      pulse_start(5);
      chk("ign_busy", 64'(busy), 64'(1));
      send_stream(2, stream.size(), 0);
      wait_done(64);
      check_writes(2);

      // Reset in the middle of a three-word load.
      fill_random(3);
      build_stream(3, 1'b0, dummy_err);
      pulse_start(3);
      send_stream(0, 6, 0);
      chk("abort_writes", 64'(wr_addr.size()), 64'(1));
      if (wr_addr.size() > 0) chk("abort_addr", 64'(wr_addr[0]), 64'(0));
      reset = 1'b1;
      cycle1();
      reset = 1'b0;
      chk("abort_hold", 64'(cpu_hold), 64'(1));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_ready", 64'(bus.byte_ready), 64'(0));
      repeat (3) cycle1();
      chk("abort_idle_we", 64'(wr_addr.size()), 64'(0));
      fill_random(1);
      run_load(1, 0, 1'b0);

      // Saturating length: 2**ADDR_W words, then no more bytes accepted.
      fill_random(CAP);
      run_load(300, 0, 1'b0);
      chk("sat_last_addr", 64'(bus.mem_addr), 64'(CAP - 1));
      bus.byte_valid = 1'b1;
      rdy = 0;
      repeat (10) begin
         @(negedge clock);
         if (bus.byte_ready) rdy++;
      end
      bus.byte_valid = 1'b0;
      chk("sat_no_ready", 64'(rdy), 64'(0));
      chk("sat_addr_hold", 64'(bus.mem_addr), 64'(CAP - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum word: correct, then off by one.
      img.delete();
      img.push_back(32'h0000_0001);
      run_load(1, 0, 1'b0);
      run_load(1, 0, 1'b1);
      chk("cs_bad_done", 64'(done), 64'(1));
`endif

      // Randomised loads against the model.
      for (int k = 0; k < 6; k++) begin
         int len;
         len = $urandom_range(1, 6);
         fill_random(len);
         run_load(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
